// File: rtl/pc_fetch_gen_pkg.sv
// Shared RISC-V encodings and the redirect decode used by the fetch generator.
package pc_fetch_gen_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP    = 32'd4;

    // An EX-stage instruction redirects fetch when it is a taken branch or any jal.
    function automatic logic is_redirect(input logic       valid,
                                         input logic [6:0] opcode,
                                         input logic       taken);
        return valid && (((opcode == OPC_BRANCH) && taken) || (opcode == OPC_JAL));
    endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Instruction-memory fetch bus: request strobe/address out, ack/data back.
interface pc_fetch_gen_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/pc_fetch_gen.sv
// PC generator and single-outstanding instruction fetcher with EX-stage redirect.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_REQ  | issue imem_req for imem_addr (first cycle after reset idles)
//   S_WAIT | request outstanding, waiting for imem_ack; addr held stable
//   S_HOLD | fetched instruction presented on if_*, waiting for if_ready
//
// A redirect seen while a fetch is outstanding cannot cancel it on the bus,
// so r_drop marks the pending ack as stale and its data is thrown away.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [6:0]    ex_opcode,
    input  logic [31:0]   ex_pc,
    input  logic [31:0]   ex_offset,
    input  logic          ex_taken,
    pc_fetch_gen_if.master imem,
    input  logic          if_ready,
    output logic          if_valid,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_instr,
    output logic          flush,
    output logic          misaligned
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_flush;
    logic        r_misaligned;
    logic        r_drop;

    logic        w_redirect;
    logic [31:0] w_target;

    assign w_redirect = is_redirect(ex_valid, ex_opcode, ex_taken);
    assign w_target   = ex_pc + ex_offset;

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_imem_addr;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instr       = r_if_instr;
    assign flush          = r_flush;
    assign misaligned     = r_misaligned;

    // Fetch FSM with registered bus/IF outputs; redirect overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'h0000_0000;
            r_if_instr   <= INSTR_NOP;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_flush <= w_redirect;
            if (w_redirect) begin
                r_pc       <= w_target;
                r_if_valid <= 1'b0;
                if (w_target[1]) begin
                    r_misaligned <= 1'b1;
                end
            end

            case (r_state)
                S_REQ: begin
                    if (w_redirect) begin
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_target;
                    end else if (!r_imem_req) begin
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                    end else begin
                        r_imem_req <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem.imem_ack) begin
                        r_drop <= 1'b0;
                        if (w_redirect) begin
                            r_state     <= S_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= w_target;
                        end else if (r_drop) begin
                            r_state     <= S_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= r_pc;
                        end else begin
                            r_if_instr <= imem.imem_rdata;
                            r_if_pc    <= r_imem_addr;
                            r_if_valid <= 1'b1;
                            r_pc       <= r_pc + PC_STEP;
                            r_state    <= S_HOLD;
                        end
                    end else if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (w_redirect) begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_target;
                    end else if (if_ready) begin
                        r_if_valid  <= 1'b0;
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                    end
                end

                default: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_gen.md
PC_FETCH_GEN -- requirements
Module: pc_fetch_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ex_valid  input  1  the EX-stage instruction is live.
REQ-005 SHALL have port ex_opcode  input  7  the EX-stage opcode.
REQ-006 SHALL have port ex_pc  input  32  the PC of the EX-stage instruction.
REQ-007 SHALL have port ex_offset  input  32  the byte offset from the branch/jal offset former (LSB always 0).
REQ-008 SHALL have port ex_taken  input  1  the branch comparator result.
REQ-009 SHALL have port imem_req  output  1  the fetch request strobe.
REQ-010 SHALL have port imem_addr  output  32  the fetch address.
REQ-011 SHALL have port imem_ack  input  1  the fetch data is valid this cycle.
REQ-012 SHALL have port imem_rdata  input  32  the fetched instruction word.
REQ-013 SHALL have port if_ready  input  1  IF/ID accepts this cycle (low = stall).
REQ-014 SHALL have port if_valid  output  1  if_pc/if_instr hold a deliverable instruction.
REQ-015 SHALL have port if_pc  output  32  the PC of the delivered instruction.
REQ-016 SHALL have port if_instr  output  32  the delivered instruction word.
REQ-017 SHALL have port flush  output  1  a one-cycle pulse squashing IF/ID and ID/EX.
REQ-018 SHALL have port misaligned  output  1  a sticky flag set when a redirect target has bit 1 set.

Function
REQ-019 Redirect SHALL be ex_valid AND ((ex_opcode==branch AND ex_taken) OR ex_opcode==jal); target = ex_pc + ex_offset, 32-bit modulo (wrap-around, no carry out).
REQ-020 SHALL implement FSM states REQ, WAIT, HOLD.
REQ-021 In REQ, imem_req SHALL be 1 with imem_addr=pc, and the FSM SHALL move to WAIT next cycle.
REQ-022 In WAIT, on imem_ack the FSM SHALL capture imem_rdata/pc into if_instr/if_pc, set if_valid, set pc=pc+4, and go to HOLD; with no ack it SHALL stay in WAIT.
REQ-023 In HOLD with if_ready=1, the FSM SHALL clear if_valid and go to REQ; with if_ready=0, outputs SHALL stay unchanged.
REQ-024 Fetch-to-delivery latency SHALL be 1 cycle after imem_ack; back-to-back throughput SHALL be one instruction every 3 cycles with single-cycle ack.
REQ-025 On redirect in any state, pc SHALL load the target, flush SHALL pulse 1 the next cycle, and if_valid SHALL clear.
REQ-026 A redirect in REQ or HOLD SHALL send the FSM to REQ.
REQ-027 A redirect in WAIT without imem_ack SHALL set a drop flag and stay in WAIT; the data of the next ack SHALL be discarded, the drop flag cleared, and the FSM sent to REQ.
REQ-028 A redirect coinciding with imem_ack SHALL discard that data and go to REQ.
REQ-029 A redirect SHALL take precedence over if_ready=0 (stall).
REQ-030 A redirect SHALL never cause pc+4 to be applied to the target in the same cycle.
REQ-031 When target[1]==1, misaligned SHALL set and hold until reset, and the redirect SHALL still be performed.
REQ-032 imem_addr SHALL be stable while the FSM is in WAIT.

Reset
REQ-033 While rst_n=0: pc=RESET_PC, state=REQ, imem_req=0, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (nop), flush=0, misaligned=0, drop=0.
REQ-034 The first imem_req SHALL assert in the first clock after rst_n deasserts.
REQ-035 Reset asserted mid-WAIT SHALL abandon the outstanding fetch; an ack arriving after reset release, before the first request, SHALL be ignored.

Structure
REQ-036 Opcode constants (branch, jal) and the nop encoding SHALL come from the shared RISC-V instruction-set include; FSM state encodings SHALL be local.
REQ-037 The block SHALL be flat with no sub-modules; the target adder is inline.

Verification
REQ-038 Reset release, ack always 1, if_ready=1 -> imem_addr sequence 0,4,8; if_pc 0,4,8 one cycle after each ack.
REQ-039 if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr hold; no new imem_req.
REQ-040 Branch redirect with ex_pc=0x100, ex_offset=0xFFFF_FFF0, ex_taken=1 in HOLD -> flush pulse, next imem_addr=0xF0.
REQ-041 Jal redirect (ex_pc=0x200, ex_offset=0x40) in WAIT with ack delayed 3 cycles -> ack data dropped, if_valid stays 0, next imem_addr=0x240.
REQ-042 Redirect target 0x102 -> misaligned=1 and sticky, imem_addr=0x102; ex_pc=0xFFFF_FFFC, ex_offset=8 -> imem_addr=0x4 (wrap).
REQ-043 rst_n low mid-WAIT, ack arrives after release -> ack ignored; first imem_addr=RESET_PC.
